pwm_spi_master: RTL and testbench
=================================

Name: pwm_spi_master

Overview:
- SPI initiator for the motor-command link. It is the transmitting end of the 16-bit frame that pwm_spi receives.
- Takes two 8-bit motor values through a valid/ready handshake and serialises them MSB-first as {motor1_in, motor2_in}, framed by load.
- Captures the 16 bits returned on sdo during the same frame (full duplex).
- Used for FPGA-to-FPGA bring-up and as the synthesizable stimulus source in system benches.

Parameters:
- CLK_DIV, 4, sck half-period in clk cycles; legal range 1..255.
- GAP_CYCLES, 8, minimum idle clk cycles between the done pulse and the next tx_ready; legal range 0..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tx_valid  input  1  request to send a frame
- tx_ready  output  1  high when a request will be accepted
- motor1_in  input  8  first byte sent (frame bits 15..8)
- motor2_in  input  8  second byte sent (frame bits 7..0)
- sck  output  1  serial clock; idles low
- sdi  output  1  serial data to the responder
- load  output  1  frame strobe; high for the whole frame, falls to commit
- sdo  input  1  serial data from the responder
- rx_data  output  16  bits captured from sdo in the last completed frame
- done  output  1  one-cycle pulse at frame completion
- busy  output  1  high from accept until the end of the gap

Behaviour:
- Reset (reset=0, asynchronous): sck=0, sdi=0, load=0, done=0, busy=0, rx_data=0, state=IDLE, all counters 0. tx_ready=1 one clk edge after reset releases.
- All outputs are registered. sck, sdi and load are free of glitches.
- States: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
- IDLE:
  - tx_ready=1, load=0, sck=0, sdi=0.
  - On a clk edge with tx_valid=1, latch shreg={motor1_in, motor2_in}, set bit index to 15, then go to SETUP.
  - On that same edge: load=1, busy=1, sdi=bit15.
- SETUP: hold sck=0 for CLK_DIV cycles (sdi setup time), then go to SCK_HI and set sck=1.
- SCK_HI:
  - Hold sck=1 for CLK_DIV cycles. The responder samples sdi on the sck rising edge.
  - On the clk edge that ends the high phase: shift sdo into rx_shift LSB, set sck=0.
  - If the bit index is 0, go to SCK_LO as the trail phase. Otherwise decrement the bit index, drive sdi with the next bit, and go to SCK_LO.
- SCK_LO:
  - Hold sck=0 for CLK_DIV cycles, then go to SCK_HI with sck=1.
  - If this was the trail phase, instead on its final edge: load=0, done=1 for one cycle, rx_data=rx_shift, sdi=0, go to GAP.
- Frame timing: load is high for exactly 33*CLK_DIV cycles, which is 132 for the default. Exactly 16 sck rising edges occur per frame, all while load=1.
- GAP: tx_ready=0, busy=1 for GAP_CYCLES cycles, then go to IDLE with busy=0. If GAP_CYCLES=0, go to IDLE on the cycle after done.
- tx_ready is 1 only in IDLE. tx_valid outside IDLE is ignored and is not queued.
- Input stability: motor1_in and motor2_in may change on any cycle after the accept edge without affecting the current frame.
- rx_data holds its value until the next done. It is not cleared at frame start.
- Reset mid-frame: all outputs return to reset values immediately. No done pulse is produced, rx_data=0, and the partial frame is discarded. The falling load does not follow a completed frame; pwm_spi tolerates this because its bit count is also reset by the system reset.
- Held tx_valid: frames run back to back. The next accept edge is GAP_CYCLES+1 cycles after the done cycle.
- Counters:
  - Divider counter is 8 bits wide, counts 0..CLK_DIV-1 and wraps.
  - Bit index is 4 bits wide.
  - No arithmetic overflow is possible within the legal parameter ranges.

Test Plan:
- Defaults, motor1_in=8'hAA, motor2_in=8'h55, single tx_valid pulse:
  - sdi sampled at each sck rising edge is 1010101001010101.
  - load is high for 132 cycles, with 16 sck rising edges.
  - done pulses once, on the cycle load falls.
- Drive pwm_spi with motor1_in=100, motor2_in=50:
  - Frame sent is 16'h6432.
  - The responder registers motor1=100, motor2=50 after load falls.
- Loopback with sdo tied to sdi, frame 16'hAA55: rx_data=16'hAA55 in the done cycle. Second frame 16'h1234: rx_data changes only at the second done.
- tx_valid held high for 3 frames: exactly 3 done pulses; each accept is exactly GAP_CYCLES+1=9 cycles after the previous done; tx_ready=0 throughout each busy period.
- reset driven low after the 7th sck rising edge:
  - sck, load, sdi, busy and rx_data go to 0 without waiting for a clk edge.
  - No done pulse.
  - A new frame after release completes normally.
- CLK_DIV=1, GAP_CYCLES=0, frame 16'hFFFF:
  - sck toggles every clk cycle.
  - load is high for 33 cycles.
  - The next accept is possible on the cycle after done.

Source files
------------

// File: rtl/pwm_spi_master_if.sv
// pwm_spi_master_if: command handshake and receive-side status between a host and pwm_spi_master.
interface pwm_spi_master_if;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  motor1_in;
    logic [7:0]  motor2_in;
    logic [15:0] rx_data;
    logic        done;
    logic        busy;
    modport master (input tx_valid, motor1_in, motor2_in, output tx_ready, rx_data, done, busy);
    modport slave  (output tx_valid, motor1_in, motor2_in, input tx_ready, rx_data, done, busy);
endinterface

// File: rtl/pwm_spi_master.sv
// pwm_spi_master: SPI initiator sending {motor1_in, motor2_in} MSB-first inside a load frame,
// capturing sdo full-duplex; all pins and status come straight from registers.
module pwm_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    pwm_spi_master_if.master bus,
    output logic             sck,
    output logic             sdi,
    output logic             load,
    input  logic             sdo
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, GAP} state_t;
    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [3:0]  idx, idx_d;
    logic [15:0] tx_shift, tx_shift_d, rx_shift, rx_shift_d, rx_data, rx_data_d;
    logic        trail, trail_d, sck_d, sdi_d, load_d, done, done_d, busy, busy_d, ready, ready_d;
    logic        div_end, gap_end;
    assign div_end      = cnt == DIV_LAST;
    assign gap_end      = cnt == GAP_LAST;
    assign bus.tx_ready = ready;
    assign bus.rx_data  = rx_data;
    assign bus.done     = done;
    assign bus.busy     = busy;
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        idx_d      = idx;
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        trail_d    = trail;
        sck_d      = sck;
        sdi_d      = sdi;
        load_d     = load;
        done_d     = 1'b0;
        busy_d     = busy;
        ready_d    = ready;
        case (state)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.tx_valid && ready) begin
                    tx_shift_d = {bus.motor1_in, bus.motor2_in};
                    idx_d      = 4'd15;
                    trail_d    = 1'b0;
                    cnt_d      = 8'd0;
                    load_d     = 1'b1;
                    busy_d     = 1'b1;
                    sdi_d      = bus.motor1_in[7];
                    ready_d    = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cnt_d = div_end ? 8'd0 : cnt + 8'd1;
                if (div_end) begin
                    sck_d   = 1'b1;
                    state_d = SCK_HI;
                end
            end
            SCK_HI: begin
                cnt_d = div_end ? 8'd0 : cnt + 8'd1;
                if (div_end) begin
                    rx_shift_d = {rx_shift[14:0], sdo};
                    sck_d      = 1'b0;
                    state_d    = SCK_LO;
                    // after the last bit one more low phase runs as the trail before load drops
                    if (idx == 4'd0) trail_d = 1'b1;
                    else begin
                        idx_d = idx - 4'd1;
                        sdi_d = tx_shift[idx - 4'd1];
                    end
                end
            end
            SCK_LO: begin
                cnt_d = div_end ? 8'd0 : cnt + 8'd1;
                if (div_end && trail) begin
                    load_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift;
                    sdi_d     = 1'b0;
                    trail_d   = 1'b0;
                    state_d   = GAP;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end else if (div_end) begin
                    sck_d   = 1'b1;
                    state_d = SCK_HI;
                end
            end
            GAP: begin
                cnt_d = gap_end ? 8'd0 : cnt + 8'd1;
                if (gap_end) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            idx      <= 4'd0;
            tx_shift <= 16'd0;
            rx_shift <= 16'd0;
            rx_data  <= 16'd0;
            trail    <= 1'b0;
            sck      <= 1'b0;
            sdi      <= 1'b0;
            load     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            idx      <= idx_d;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            rx_data  <= rx_data_d;
            trail    <= trail_d;
            sck      <= sck_d;
            sdi      <= sdi_d;
            load     <= load_d;
            done     <= done_d;
            busy     <= busy_d;
            ready    <= ready_d;
        end
    end
endmodule

// File: tb/tb_pwm_spi_master.sv
// tb_pwm_spi_master: vector table of frames on the default instance plus hand sequences for
// back-to-back frames, mid-frame reset and the CLK_DIV=1 / GAP_CYCLES=0 instance.
module tb_pwm_spi_master;
    typedef struct {
        logic [7:0]  m1, m2;
        logic [1:0]  mode;
        logic [15:0] frame, rx;
    } vec_t;
    logic clk = 1'b0, reset;
    logic sck0, sdi0, load0, sdo0, loop0, sdo_c;
    logic sck1, sdi1, load1, sdo1;
    pwm_spi_master_if bus0 ();
    pwm_spi_master_if bus1 ();
    assign sdo0 = loop0 ? sdi0 : sdo_c;
    assign sdo1 = 1'b0;
    pwm_spi_master u0 (.clk(clk), .reset(reset), .bus(bus0), .sck(sck0), .sdi(sdi0), .load(load0), .sdo(sdo0));
    pwm_spi_master #(.CLK_DIV(1), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .bus(bus1), .sck(sck1), .sdi(sdi1), .load(load1), .sdo(sdo1));
    always #5 clk = ~clk;
    int errors = 0, checks = 0, cyc = 0;
    int ld0 = 0, rise0 = 0, done_n0 = 0, last_done0 = 0, acc0 = 0, gap0 = 0, rbad0 = 0, dbad0 = 0, rb0 = 0;
    int ld1 = 0, rise1 = 0, tog1 = 0, done_n1 = 0, last_done1 = 0, acc1 = 0, gap1 = 0;
    logic sck0_p = 1'b0, load0_p = 1'b0, sck1_p = 1'b0, load1_p = 1'b0;
    logic [15:0] bits0 = 16'd0, bits1 = 16'd0, rsp = 16'd0, rsp_out = 16'd0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        sck0_p  <= sck0;
        load0_p <= load0;
        if (load0) ld0 <= ld0 + 1;
        if (sck0 && !sck0_p) begin
            rise0 <= rise0 + 1;
            bits0 <= {bits0[14:0], sdi0};
            if (!load0) rbad0 <= rbad0 + 1;
        end
        if (bus0.done) begin
            done_n0    <= done_n0 + 1;
            last_done0 <= cyc;
            if (!(load0_p && !load0)) dbad0 <= dbad0 + 1;
        end
        if (bus0.busy && bus0.tx_ready) rb0 <= rb0 + 1;
        if (bus0.tx_valid && bus0.tx_ready) begin
            acc0 <= acc0 + 1;
            gap0 <= cyc + 1 - (bus0.done ? cyc : last_done0);
        end
    end
    always @(negedge clk) begin
        sck1_p  <= sck1;
        load1_p <= load1;
        if (load1) ld1 <= ld1 + 1;
        if (load1 && load1_p && sck1 != sck1_p) tog1 <= tog1 + 1;
        if (sck1 && !sck1_p) begin
            rise1 <= rise1 + 1;
            bits1 <= {bits1[14:0], sdi1};
        end
        if (bus1.done) begin
            done_n1    <= done_n1 + 1;
            last_done1 <= cyc;
        end
        if (bus1.tx_valid && bus1.tx_ready) begin
            acc1 <= acc1 + 1;
            gap1 <= cyc + 1 - (bus1.done ? cyc : last_done1);
        end
    end
    // minimal responder: shift sdi on sck rise, commit on load fall
    always @(posedge sck0) rsp <= {rsp[14:0], sdi0};
    always @(negedge load0) rsp_out <= rsp;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask
    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic send0(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        while (!bus0.tx_ready && t < 1000) begin
            tick;
            t++;
        end
        if (!bus0.tx_ready) fail("tx_ready_wait");
        bus0.tx_valid  = 1'b1;
        bus0.motor1_in = a;
        bus0.motor2_in = b;
        @(posedge clk);
        #1;
        bus0.tx_valid  = 1'b0;
        bus0.motor1_in = 8'($urandom);
        bus0.motor2_in = 8'($urandom);
    endtask
    task automatic wait_done0(input logic [15:0] prev, output int hb);
        int t = 0;
        hb = 0;
        tick;
        while (!bus0.done && t < 600) begin
            if (bus0.rx_data !== prev) hb++;
            tick;
            t++;
        end
        if (!bus0.done) fail("done_wait");
    endtask
    vec_t v[5];
    initial begin
        int l, r, d, a, pa, hb, g, t, tg;
        logic [15:0] prev;
        v[0] = '{m1: 8'hAA, m2: 8'h55, mode: 2'd2, frame: 16'hAA55, rx: 16'hAA55};
        v[1] = '{m1: 8'd100, m2: 8'd50, mode: 2'd1, frame: 16'h6432, rx: 16'hFFFF};
        v[2] = '{m1: 8'h12, m2: 8'h34, mode: 2'd2, frame: 16'h1234, rx: 16'h1234};
        v[3] = '{m1: 8'h00, m2: 8'hFF, mode: 2'd0, frame: 16'h00FF, rx: 16'h0000};
        v[4] = '{m1: 8'h80, m2: 8'h01, mode: 2'd2, frame: 16'h8001, rx: 16'h8001};
        reset = 1'b0;
        loop0 = 1'b1;
        sdo_c = 1'b0;
        bus0.tx_valid = 1'b0; bus0.motor1_in = 8'd0; bus0.motor2_in = 8'd0;
        bus1.tx_valid = 1'b0; bus1.motor1_in = 8'd0; bus1.motor2_in = 8'd0;
        repeat (3) tick;
        chk("reset_pins", {26'd0, sck0, sdi0, load0, bus0.done, bus0.busy, bus0.tx_ready}, 32'd0);
        chk("reset_rx", bus0.rx_data, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", bus0.tx_ready, 1);
        prev = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            loop0 = v[i].mode == 2'd2;
            sdo_c = v[i].mode[0];
            l = ld0; r = rise0; d = done_n0;
            send0(v[i].m1, v[i].m2);
            wait_done0(prev, hb);
            chk("rx_data", bus0.rx_data, v[i].rx);
            chk("sdi_bits", bits0, v[i].frame);
            chk("responder", rsp_out, v[i].frame);
            chk("load_cycles", ld0 - l, 132);
            chk("sck_rises", rise0 - r, 16);
            chk("done_pulses", done_n0 - d, 1);
            chk("rx_hold", hb, 0);
            g = 0;
            for (int k = 0; k < 7; k++) begin
                tick;
                if (!bus0.busy || bus0.tx_ready) g++;
            end
            tick;
            chk("gap_busy", g, 0);
            chk("gap_end", {bus0.tx_ready, bus0.busy}, 2'b10);
            prev = v[i].rx;
        end
        chk("sck_outside_load", rbad0, 0);
        chk("done_on_load_fall", dbad0, 0);
        d = done_n0; a = acc0; pa = acc0; t = 0;
        bus0.tx_valid = 1'b1; bus0.motor1_in = 8'h12; bus0.motor2_in = 8'h34;
        while (acc0 - a < 2 && t < 2000) begin
            tick;
            t++;
            if (acc0 != pa) begin
                pa = acc0;
                chk("b2b_accept_gap", gap0, 9);
            end
        end
        if (acc0 - a < 2) fail("b2b_accepts");
        @(posedge clk);
        #1;
        bus0.tx_valid = 1'b0;
        t = 0;
        while (done_n0 - d < 3 && t < 2000) begin
            tick;
            t++;
        end
        repeat (30) tick;
        chk("b2b_done_pulses", done_n0 - d, 3);
        chk("ready_while_busy", rb0, 0);
        d = done_n0; r = rise0; t = 0;
        send0(8'hC3, 8'h5A);
        while (rise0 - r < 7 && t < 500) begin
            tick;
            t++;
        end
        if (rise0 - r < 7) fail("rise7_wait");
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_pins", {28'd0, sck0, load0, sdi0, bus0.busy}, 32'd0);
        chk("mid_reset_rx", bus0.rx_data, 16'h0000);
        repeat (5) tick;
        chk("mid_reset_no_done", done_n0 - d, 0);
        reset = 1'b1;
        repeat (2) tick;
        l = ld0; r = rise0;
        send0(8'h3C, 8'hC3);
        wait_done0(16'h0000, hb);
        chk("post_reset_rx", bus0.rx_data, 16'h3CC3);
        chk("post_reset_bits", bits0, 16'h3CC3);
        chk("post_reset_load", ld0 - l, 132);
        chk("post_reset_hold", hb, 0);
        l = ld1; r = rise1; tg = tog1; d = done_n1; a = acc1; t = 0;
        bus1.tx_valid = 1'b1; bus1.motor1_in = 8'hFF; bus1.motor2_in = 8'hFF;
        while (done_n1 - d < 1 && t < 200) begin
            tick;
            t++;
        end
        if (done_n1 - d < 1) fail("fast_done_wait");
        chk("fast_load_cycles", ld1 - l, 33);
        chk("fast_rises", rise1 - r, 16);
        chk("fast_toggles", tog1 - tg, 32);
        chk("fast_bits", bits1, 16'hFFFF);
        chk("fast_rx", bus1.rx_data, 16'h0000);
        t = 0;
        while (acc1 == a && t < 200) begin
            tick;
            t++;
        end
        if (acc1 == a) fail("fast_accept_wait");
        chk("fast_accept_gap", gap1, 1);
        @(posedge clk);
        #1;
        bus1.tx_valid = 1'b0;
        t = 0;
        while (done_n1 - d < 2 && t < 200) begin
            tick;
            t++;
        end
        repeat (10) tick;
        chk("fast_done_pulses", done_n1 - d, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
